// File: rtl/lfsr_galois_gen.sv
// Parametrised Galois right-shift LFSR with seed load, lockup guard, step counter and period-wrap flag.
// Optional macro LFSR_REVERSE_EN adds a dir input for backward stepping.
module lfsr_galois_gen #(
    parameter int                WIDTH = 16,
    parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0]  SEED  = 16'h0001,
    parameter int                STEPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
`ifdef LFSR_REVERSE_EN
    input  logic             dir,
`endif
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt
);

    // An all-zero seed would trap the register forever, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_SAFE = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] ref_state;
    logic [WIDTH-1:0] adv_state;
    logic [WIDTH-1:0] cnt_next;

    function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] s);
        return {1'b0, s[WIDTH-1:1]} ^ (s[0] ? TAPS : '0);
    endfunction

`ifdef LFSR_REVERSE_EN
    // Undo one forward step: a set MSB means the dropped LSB was 1 and TAPS was applied.
    function automatic logic [WIDTH-1:0] step_bwd(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s ^ TAPS;
        return s[WIDTH-1] ? {t[WIDTH-2:0], 1'b1} : {s[WIDTH-2:0], 1'b0};
    endfunction
`endif

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        adv_state = state;
        cnt_next  = step_cnt + WIDTH'(1);
`ifdef LFSR_REVERSE_EN
        if (dir) begin
            cnt_next = step_cnt - WIDTH'(1);
            for (int i = 0; i < STEPS; i++) adv_state = step_bwd(adv_state);
        end else begin
            for (int i = 0; i < STEPS; i++) adv_state = step_fwd(adv_state);
        end
`else
        for (int i = 0; i < STEPS; i++) adv_state = step_fwd(adv_state);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SEED_SAFE;
            ref_state <= SEED_SAFE;
            step_cnt  <= '0;
            lockup    <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            lockup <= 1'b0;
            wrap   <= 1'b0;
            if (load) begin
                step_cnt <= '0;
                if (seed_in != '0) begin
                    state     <= seed_in;
                    ref_state <= seed_in;
                end else begin
                    state     <= SEED_SAFE;
                    ref_state <= SEED_SAFE;
                    lockup    <= 1'b1;
                end
            end else if (en) begin
                if (state == '0) begin
                    // Only reachable with a non-primitive TAPS that leaks into zero.
                    state  <= SEED_SAFE;
                    lockup <= 1'b1;
                end else begin
                    state    <= adv_state;
                    step_cnt <= cnt_next;
                    wrap     <= (adv_state == ref_state);
                end
            end
        end
    end

    assign bit_out = state[0];

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// Self-checking bench for lfsr_galois_gen: directed vector table, hand sequences and a randomized
// run against an arithmetic reference model. Covers the LFSR_REVERSE_EN build when the macro is set.
module tb_lfsr_galois_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: defaults
    logic        a_rst_n, a_en, a_load, a_dir, a_bit, a_lock, a_wrap;
    logic [15:0] a_seed, a_state, a_cnt;
    // Instance B: STEPS=3
    logic        b_rst_n, b_en, b_load, b_dir, b_bit, b_lock, b_wrap;
    logic [15:0] b_seed, b_state, b_cnt;
    // Instance C: 5-bit
    logic        c_rst_n, c_en, c_load, c_dir, c_bit, c_lock, c_wrap;
    logic [4:0]  c_seed, c_state, c_cnt;

    lfsr_galois_gen u_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .load(a_load),
`ifdef LFSR_REVERSE_EN
        .dir(a_dir),
`endif
        .seed_in(a_seed), .state(a_state), .bit_out(a_bit),
        .lockup(a_lock), .wrap(a_wrap), .step_cnt(a_cnt)
    );

    lfsr_galois_gen #(.STEPS(3)) u_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .load(b_load),
`ifdef LFSR_REVERSE_EN
        .dir(b_dir),
`endif
        .seed_in(b_seed), .state(b_state), .bit_out(b_bit),
        .lockup(b_lock), .wrap(b_wrap), .step_cnt(b_cnt)
    );

    lfsr_galois_gen #(.WIDTH(5), .TAPS(5'h12), .SEED(5'h01), .STEPS(1)) u_c (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .load(c_load),
`ifdef LFSR_REVERSE_EN
        .dir(c_dir),
`endif
        .seed_in(c_seed), .state(c_state), .bit_out(c_bit),
        .lockup(c_lock), .wrap(c_wrap), .step_cnt(c_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one Galois step in plain integer arithmetic, forward or inverse.
    function automatic int unsigned m_step(input int unsigned s, input int unsigned taps,
                                           input int w, input bit rev);
        int unsigned modv = 32'd1 << w;
        if (!rev) return (s % 2 == 1) ? ((s / 2) ^ taps) : (s / 2);
        if (s >= modv / 2) return (((s ^ taps) * 2) + 1) % modv;
        return (s * 2) % modv;
    endfunction

    typedef struct {
        int unsigned st;
        int unsigned rf;
        int unsigned cnt;
        bit          lk;
        bit          wr;
    } model_t;

    // Reference model for a 16-bit instance with TAPS=B400, SEED=1.
    function automatic model_t m_update(input model_t m, input bit rst_n, input bit load,
                                        input bit en, input bit rev, input int unsigned seed,
                                        input int steps);
        model_t n = m;
        int unsigned s;
        n.lk = 1'b0;
        n.wr = 1'b0;
        if (!rst_n) begin
            n.st = 1; n.rf = 1; n.cnt = 0;
        end else if (load) begin
            n.cnt = 0;
            if (seed != 0) begin n.st = seed; n.rf = seed; end
            else begin n.st = 1; n.rf = 1; n.lk = 1'b1; end
        end else if (en) begin
            if (m.st == 0) begin
                n.st = 1; n.lk = 1'b1;
            end else begin
                s = m.st;
                for (int k = 0; k < steps; k++) s = m_step(s, 32'hB400, 16, rev);
                n.st  = s;
                n.cnt = rev ? (m.cnt + 65535) % 65536 : (m.cnt + 1) % 65536;
                n.wr  = (s == m.rf);
            end
        end
        return n;
    endfunction

    typedef struct {
        logic        rst_n;
        logic        load;
        logic        en;
        logic [15:0] seed;
        logic [15:0] st;
        logic [15:0] cnt;
        logic        lk;
        logic        wr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        model_t ma, mb;
        bit     seen [32];
        int     dups;
        int unsigned mc;
        int unsigned r;

        a_rst_n = 0; a_en = 0; a_load = 0; a_dir = 0; a_seed = '0;
        b_rst_n = 0; b_en = 0; b_load = 0; b_dir = 0; b_seed = '0;
        c_rst_n = 0; c_en = 0; c_load = 0; c_dir = 0; c_seed = '0;

        // rst_n, load, en, seed_in -> state, step_cnt, lockup, wrap
        tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'hACE1, 16'hACE1, 16'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hE270, 16'd1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h7138, 16'd2, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h389C, 16'd3, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h389C, 16'd3, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 16'd0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'd0, 1'b0, 1'b0};

        foreach (tbl[i]) begin
            a_rst_n = tbl[i].rst_n; a_load = tbl[i].load; a_en = tbl[i].en; a_seed = tbl[i].seed;
            tick();
            check($sformatf("tbl%0d_state", i), a_state, tbl[i].st);
            check($sformatf("tbl%0d_bit", i), a_bit, tbl[i].st[0]);
            check($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_lockup", i), a_lock, tbl[i].lk);
            check($sformatf("tbl%0d_wrap", i), a_wrap, tbl[i].wr);
        end

        // Reset mid-run with en still high discards progress.
        a_load = 1; a_en = 0; a_seed = 16'hACE1;
        tick();
        a_load = 0; a_en = 1;
        repeat (10) tick();
        check("run10_cnt", a_cnt, 32'd10);
        a_rst_n = 0;
        tick();
        check("rst_state", a_state, 32'h0001);
        check("rst_cnt", a_cnt, 32'd0);
        check("rst_wrap", a_wrap, 1'b0);
        check("rst_lockup", a_lock, 1'b0);
        a_rst_n = 1; a_en = 0;
        repeat (3) tick();
        check("hold_state", a_state, 32'h0001);
        check("hold_cnt", a_cnt, 32'd0);

`ifdef LFSR_REVERSE_EN
        a_load = 1; a_seed = 16'hACE1;
        tick();
        a_load = 0; a_en = 1; a_dir = 0;
        tick();
        check("rev_fwd_state", a_state, 32'hE270);
        a_dir = 1;
        tick();
        check("rev_back_state", a_state, 32'hACE1);
        check("rev_back_cnt", a_cnt, 32'd0);
        check("rev_back_wrap", a_wrap, 1'b1);
        tick();
        check("rev_under_cnt", a_cnt, 32'hFFFF);
        a_en = 0; a_dir = 0;
`endif

        // STEPS=3: one enable covers three single steps.
        b_rst_n = 1; b_load = 1; b_seed = 16'hACE1;
        tick();
        b_load = 0; b_en = 1;
        tick();
        b_en = 0;
        check("steps3_state", b_state, 32'h389C);
        check("steps3_cnt", b_cnt, 32'd1);

        // 5-bit maximal sequence: every nonzero state once, wrap exactly at the period.
        tick();
        c_rst_n = 1; c_en = 1;
        mc   = 1;
        dups = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            mc = m_step(mc, 32'h12, 5, 1'b0);
            check($sformatf("w5_state%0d", k), c_state, mc);
            check($sformatf("w5_wrap%0d", k), c_wrap, (k == 31));
            if (seen[c_state]) dups++;
            seen[c_state] = 1'b1;
        end
        c_en = 0;
        check("w5_dups", dups, 0);
        check("w5_zero_seen", seen[0], 1'b0);
        check("w5_final_state", c_state, 32'h01);
        check("w5_final_cnt", c_cnt, 32'd31);
        tick();
        check("w5_wrap_drop", c_wrap, 1'b0);

        // Randomized run on A and B with a shared input stream.
        a_rst_n = 0; b_rst_n = 0; a_load = 0; b_load = 0; a_en = 0; b_en = 0; a_dir = 0;
        tick();
        ma = '{1, 1, 0, 1'b0, 1'b0};
        mb = '{1, 1, 0, 1'b0, 1'b0};
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            a_rst_n = (r % 50) != 0;
            a_load  = ((r >> 8) % 8) == 0;
            a_en    = ((r >> 12) % 4) != 0;
            a_seed  = (((r >> 16) % 6) == 0) ? 16'h0000 : 16'($urandom);
`ifdef LFSR_REVERSE_EN
            a_dir   = ((r >> 24) % 3) == 0;
`endif
            b_rst_n = a_rst_n; b_load = a_load; b_en = a_en; b_seed = a_seed;
            ma = m_update(ma, a_rst_n, a_load, a_en, a_dir, a_seed, 1);
            mb = m_update(mb, b_rst_n, b_load, b_en, 1'b0, b_seed, 3);
            tick();
            check("rnd_a_state", a_state, ma.st);
            check("rnd_a_bit", a_bit, ma.st[0]);
            check("rnd_a_cnt", a_cnt, ma.cnt);
            check("rnd_a_lockup", a_lock, ma.lk);
            check("rnd_a_wrap", a_wrap, ma.wr);
            check("rnd_b_state", b_state, mb.st);
            check("rnd_b_cnt", b_cnt, mb.cnt);
            check("rnd_b_lockup", b_lock, mb.lk);
            check("rnd_b_wrap", b_wrap, mb.wr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_galois_gen.md
Name: lfsr_galois_gen

Overview:
Parametrised Galois-form LFSR pseudo-random generator, the configurable replacement for the fixed 5-bit internal-XOR LFSR. Width, feedback mask, reset seed and steps-per-enable are generic. Adds a runtime seed-load port, a clock enable, an all-zero lockup guard with auto-reseed, and a step counter with a period-wrap flag. Used as the test-pattern / scrambler source in the datapath.

Parameters:
WIDTH, 16, state width in bits (3..32).
TAPS, 16'hB400, Galois feedback mask for right-shift form; bit WIDTH-1 must be set. Default is x^16+x^14+x^13+x^11+1, maximal length.
SEED, 16'h0001, reset and fallback state; must be nonzero, and 0 is replaced by 1 at elaboration.
STEPS, 1, LFSR advances per enabled cycle (1..WIDTH).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
en  in  1  advance STEPS steps this cycle
load  in  1  load seed_in this cycle
seed_in  in  WIDTH  runtime seed
state  out  WIDTH  current LFSR state (registered)
bit_out  out  1  state[0]; serial PRBS bit
lockup  out  1  one-cycle pulse: zero state/seed trapped, SEED substituted
wrap  out  1  one-cycle pulse: state returned to reference (period completed)
step_cnt  out  WIDTH  steps since last load/reset, mod 2^WIDTH

Behaviour:
- Single step, Galois right-shift. If s[0]=1, next = (s>>1) ^ TAPS; otherwise next = s>>1.
- Each enabled cycle applies the single step STEPS times combinationally. No pipeline: the new state appears in the cycle after en.
- Priority: rst_n=0 > load > en > hold.
- Reset (rst_n=0 at a clk edge): state=SEED, ref=SEED, step_cnt=0, lockup=0, wrap=0. Reset mid-run discards the current state.
- load=1:
  - seed_in nonzero: state=seed_in, ref=seed_in.
  - seed_in zero: state=SEED, ref=SEED, lockup=1 for one cycle.
  - In both cases step_cnt=0 and wrap=0.
- en=1, load=0:
  - If state is zero (illegal TAPS only), state=SEED and lockup=1.
  - Otherwise state advances and step_cnt increments by 1, wrapping at 2^WIDTH.
  - wrap=1 in the cycle the new state equals ref, i.e. after a full period. The pulse is registered alongside state.
- en=0, load=0: state, step_cnt and ref hold; lockup=0, wrap=0.
- load and en together: load wins and no advance occurs.
- lockup and wrap are never high for more than one consecutive cycle unless the triggering event repeats.
- ref is an internal register, not a port.
- Period is 2^WIDTH-1 for a primitive TAPS. The wrap check compares the state after all STEPS sub-steps only.

Optional Feature:
Macro LFSR_REVERSE_EN.
- Defined: adds input port dir (1 bit).
  - dir=1 with en steps backwards STEPS times per cycle.
  - Inverse step: if s[WIDTH-1]=1, prev = ((s ^ TAPS)<<1) | 1; otherwise prev = s<<1.
  - step_cnt decrements (wraps 0 to 2^WIDTH-1).
  - wrap fires on reaching ref in either direction.
  - lockup rules are unchanged.
- Not defined: no dir port, forward stepping only. Logic and behaviour otherwise identical.

Test Plan:
1. Defaults; reset, load seed_in=16'hACE1, then en for 3 cycles -> state 16'hE270, 16'h7138, 16'h389C; bit_out 1,0,0,0 across the four states; step_cnt 1,2,3.
2. STEPS=3, load 16'hACE1, one en cycle -> state 16'h389C, step_cnt=1.
3. WIDTH=5, TAPS=5'h12, SEED=5'h01; reset, en held 31 cycles -> all 31 nonzero states seen once; wrap pulses exactly on cycle 31 with state=5'h01, step_cnt=31.
4. load with seed_in=0 -> state=SEED, lockup high one cycle then low, step_cnt=0. load and en both high with seed_in=16'h1234 -> state=16'h1234, no advance.
5. Run 10 steps, then rst_n=0 for one edge while en=1 -> state=SEED, step_cnt=0, wrap=0, lockup=0. en=0 afterwards -> state holds.
6. With LFSR_REVERSE_EN: from 16'hACE1 forward one step to 16'hE270, then dir=1 one step -> 16'hACE1, step_cnt back to 0, wrap=1.
